if_fetch_unit: RTL

Instruction-fetch stage directly upstream of the next-PC logic. Owns the architectural PC register and drives pc_o, which the next-PC logic consumes. Fetches the instruction word at pc_o from a variable-latency instruction memory over a req/ack handshake, then presents the word to decode with a valid/ready handshake. Loads the externally computed npc_i when decode accepts the instruction.

---
 rtl/if_fetch_unit_pkg.sv | 25 ++
 rtl/if_fetch_unit_pc_reg.sv | 27 ++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// default parameter values and PC alignment helpers.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10,
        S_ERR   = 2'b11
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam int          DEFAULT_WAIT_MAX = 15;
    localparam int          DEFAULT_CNT_W    = 4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ~WORD_MASK) != 32'h0;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// 32-bit architectural PC register with load enable and asynchronous
// active-high reset to a parameterised value.
module if_fetch_unit_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack, hands the
// word to decode over valid/ready. Optional macro: FETCH_ALIGN_CHK_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          WAIT_MAX = DEFAULT_WAIT_MAX,
    parameter int          CNT_W    = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        stall,
    input  logic        inst_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    output logic        fetch_err
);

    // Handshakes: imem transfer happens on a cycle with imem_req && imem_ack;
    // decode transfer happens on a cycle with inst_valid && inst_ready && !stall.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc_q, pc_d;
    logic             pc_en;
    logic             accept;

    assign accept = (state_q == S_VALID) && inst_ready && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        pc_en   = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        pc_d    = npc_i;
`else
        pc_d    = word_align(npc_i);
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VALID: begin
                if (accept) begin
                    pc_en   = 1'b1;
                    state_d = S_REQ;
`ifdef FETCH_ALIGN_CHK_EN
                    // A misaligned target is still recorded in pc_o for debug.
                    if (is_misaligned(npc_i)) begin
                        state_d = S_ERR;
                    end
`endif
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    if_fetch_unit_pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    assign imem_req   = (state_q == S_REQ);
    assign inst_valid = (state_q == S_VALID);
    assign fetch_err  = (state_q == S_ERR);
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;

endmodule
